first_nios2_system_irq_ctrl: RTL and testbench

- Avalon-MM interrupt aggregator sitting directly downstream of the interval timer and the other peripheral irq sources.
- Collects up to 16 irq lines (timer irq on bit 0) and applies per-source mask and edge/level mode.
- Latches edge events, exposes pending, active and priority-vector registers.
- Drives one combined registered irq to the Nios II CPU.

---
 rtl/first_nios2_system_irq_ctrl_if.sv | 22 ++
 rtl/first_nios2_system_irq_ctrl.sv | 109 ++++++++++
 tb/tb_first_nios2_system_irq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/first_nios2_system_irq_ctrl_if.sv
// Avalon-MM slave bus plus irq source/sink lines for the Nios II interrupt aggregator.
interface first_nios2_system_irq_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [NUM_IRQ-1:0] irq_in;
  logic [15:0]        readdata;
  logic               irq;

  modport master (
    output address, chipselect, write_n, writedata, irq_in,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata, irq_in,
    output readdata, irq
  );
endinterface

// File: rtl/first_nios2_system_irq_ctrl.sv
// Interrupt aggregator: per-source mask and edge/level mode, pending/active/vector registers.
// Define IRQ_CTRL_SYNC_EN to insert a 2-flop synchronizer on irq_in for asynchronous sources.
module first_nios2_system_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic clk,
  input  logic reset_n,
  first_nios2_system_irq_ctrl_if.slave bus
);

  localparam logic [15:0] ValidMask = 16'((32'd1 << NUM_IRQ) - 32'd1);

  logic [15:0] irqInExt;
  logic [15:0] irqSrc;
  logic [15:0] irqS_q, irqPrev_q, pendE_q, mask_q, edge_q, readdata_q;
  logic        irq_q;
  logic [15:0] pendE_d, readdata_d;
  logic [15:0] rise, pending, active, vector;
  logic [15:0] setBits, clrBits;
  logic [3:0]  vecIdx;
  logic        wr, wrStatus, wrMask, wrEdge, wrForce;

  always_comb begin
    irqInExt = '0;
    irqInExt[NUM_IRQ-1:0] = bus.irq_in;
  end

`ifdef IRQ_CTRL_SYNC_EN
  logic [15:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irqInExt;
      sync2_q <= sync1_q;
    end
  end

  assign irqSrc = sync2_q;
`else
  assign irqSrc = irqInExt;
`endif

  assign wr       = bus.chipselect & ~bus.write_n;
  assign wrStatus = wr & (bus.address == 3'd0);
  assign wrMask   = wr & (bus.address == 3'd1);
  assign wrEdge   = wr & (bus.address == 3'd2);
  assign wrForce  = wr & (bus.address == 3'd5);

  assign rise    = irqS_q & ~irqPrev_q;
  assign pending = (edge_q & pendE_q) | (~edge_q & irqS_q);
  assign active  = pending & mask_q;

  // Sets are applied after clears so a rise or FORCE coinciding with W1C is never lost.
  always_comb begin
    clrBits = '0;
    if (wrStatus) clrBits = clrBits | (bus.writedata & edge_q);
    if (wrEdge)   clrBits = clrBits | ((bus.writedata & ValidMask) ^ edge_q);
    setBits = rise & edge_q;
    if (wrForce)  setBits = setBits | (bus.writedata & edge_q);
    pendE_d = ((pendE_q & ~clrBits) | setBits) & ValidMask;
  end

  always_comb begin
    vecIdx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) vecIdx = 4'(i);
    end
    vector = {|active, 11'd0, vecIdx};
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      3'd0:    readdata_d = pending;
      3'd1:    readdata_d = mask_q;
      3'd2:    readdata_d = edge_q;
      3'd3:    readdata_d = active;
      3'd4:    readdata_d = vector;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqS_q     <= '0;
      irqPrev_q  <= '0;
      pendE_q    <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqS_q     <= irqSrc & ValidMask;
      irqPrev_q  <= irqS_q;
      pendE_q    <= pendE_d;
      if (wrMask) mask_q <= bus.writedata & ValidMask;
      if (wrEdge) edge_q <= bus.writedata & ValidMask;
      readdata_q <= readdata_d;
      irq_q      <= |active;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_first_nios2_system_irq_ctrl.sv
// Directed testbench for first_nios2_system_irq_ctrl with hand-computed expectations.
module tb_first_nios2_system_irq_ctrl;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  first_nios2_system_irq_ctrl_if #(.NUM_IRQ(8)) bus ();

  first_nios2_system_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] addr, input logic [15:0] expected);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick();
    bus.chipselect = 1'b0;
    checkOutput(tag, bus.readdata, expected);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.irq_in     = '0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // Reset state: every address reads zero and irq is low
    checkOutput("reset_irq", {15'd0, bus.irq}, 16'h0000);
    for (int a = 0; a < 8; a++) readCheck($sformatf("reset_rd%0d", a), 3'(a), 16'h0000);

    // Level source 0: two clocks in, two clocks out
    applyStimulus(3'd1, 16'h0001);
    bus.irq_in[0] = 1'b1;
    tick();
    checkOutput("lvl_irq_1clk", {15'd0, bus.irq}, 16'h0000);
    tick();
    checkOutput("lvl_irq_2clk", {15'd0, bus.irq}, 16'h0001);
    readCheck("lvl_status", 3'd0, 16'h0001);
    bus.irq_in[0] = 1'b0;
    tick();
    checkOutput("lvl_drop_1clk", {15'd0, bus.irq}, 16'h0001);
    tick();
    checkOutput("lvl_drop_2clk", {15'd0, bus.irq}, 16'h0000);

    // Edge source 2: one-cycle pulse latches until W1C
    applyStimulus(3'd2, 16'h0004);
    applyStimulus(3'd1, 16'h0004);
    bus.irq_in[2] = 1'b1;
    tick();
    bus.irq_in[2] = 1'b0;
    tick();
    checkOutput("edge_irq_2clk", {15'd0, bus.irq}, 16'h0000);
    tick();
    checkOutput("edge_irq_3clk", {15'd0, bus.irq}, 16'h0001);
    readCheck("edge_status", 3'd0, 16'h0004);
    tick();
    tick();
    checkOutput("edge_sustain", {15'd0, bus.irq}, 16'h0001);
    applyStimulus(3'd0, 16'h0004);
    checkOutput("w1c_irq_1clk", {15'd0, bus.irq}, 16'h0001);
    tick();
    checkOutput("w1c_irq_2clk", {15'd0, bus.irq}, 16'h0000);
    readCheck("w1c_status", 3'd0, 16'h0000);

    // Edge source 3: rise coincident with W1C keeps the event
    applyStimulus(3'd2, 16'h000C);
    readCheck("edge_reg", 3'd2, 16'h000C);
    bus.irq_in[3] = 1'b1;
    tick();
    applyStimulus(3'd0, 16'h0008);
    bus.irq_in[3] = 1'b0;
    readCheck("rise_beats_w1c", 3'd0, 16'h0008);
    applyStimulus(3'd0, 16'h0008);
    readCheck("w1c_bit3", 3'd0, 16'h0000);

    // Priority vector with level sources 5 and 2
    applyStimulus(3'd2, 16'h0000);
    applyStimulus(3'd1, 16'h00FF);
    bus.irq_in = 8'h24;
    tick();
    readCheck("vector_2_5", 3'd4, 16'h8002);
    readCheck("active_2_5", 3'd3, 16'h0024);
    bus.irq_in = 8'h20;
    tick();
    readCheck("vector_5", 3'd4, 16'h8005);
    bus.irq_in = 8'h00;
    tick();
    readCheck("vector_none", 3'd4, 16'h0000);

    // FORCE on an edge source, masked then unmasked
    applyStimulus(3'd1, 16'h0000);
    applyStimulus(3'd2, 16'h0010);
    applyStimulus(3'd5, 16'h0010);
    readCheck("force_status", 3'd0, 16'h0010);
    readCheck("force_active", 3'd3, 16'h0000);
    checkOutput("force_masked_irq", {15'd0, bus.irq}, 16'h0000);
    readCheck("force_read0", 3'd5, 16'h0000);
    readCheck("reserved6", 3'd6, 16'h0000);
    applyStimulus(3'd1, 16'h0010);
    tick();
    checkOutput("force_unmask_irq", {15'd0, bus.irq}, 16'h0001);

    // Bits above NUM_IRQ are tied off
    applyStimulus(3'd1, 16'hFFFF);
    readCheck("mask_upper", 3'd1, 16'h00FF);

    // Asynchronous reset mid-operation
    checkOutput("pre_reset_rd", bus.readdata, 16'h00FF);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_irq", {15'd0, bus.irq}, 16'h0000);
    checkOutput("async_rd", bus.readdata, 16'h0000);
    #3 reset_n = 1'b1;
    tick();
    readCheck("post_reset_status", 3'd0, 16'h0000);
    readCheck("post_reset_mask", 3'd1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
